// File: rtl/cursor_place_ctrl.sv
// Cursor holder and stone placement sequencer for the board game.
// Moves the cursor with wrap-around and runs a read-check-write cycle on the board RAM.
module cursor_place_ctrl #(
    parameter int         BOARD_N     = 6,
    parameter logic [1:0] FIRST_STONE = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    input  logic [5:0] cell_addr,
    output logic [5:0] board_addr,
    output logic       board_rd_en,
    input  logic [1:0] board_rd_data,
    output logic       board_wr_en,
    output logic [1:0] board_wr_data,
    output logic [1:0] turn,
    output logic       busy,
    output logic       placed,
    output logic       rejected,
    output logic [5:0] stone_count,
    output logic       board_full
);

    localparam logic [2:0] MAXC  = 3'(BOARD_N - 1);
    localparam logic [5:0] CELLS = 6'(BOARD_N * BOARD_N);

    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, REJECT} state_t;
    state_t state, state_nxt;

    function automatic logic [2:0] step_axis(input logic [2:0] c, input logic dec, input logic inc);
        logic [2:0] r;
        r = c;
        if (dec && !inc)      r = (c == 3'd0) ? MAXC : c - 3'd1;
        else if (inc && !dec) r = (c == MAXC) ? 3'd0 : c + 3'd1;
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_place) state_nxt = board_full ? REJECT : READ;
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = (board_rd_data == 2'b00) ? WRITE : REJECT;
            WRITE:   state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cursor_x    <= 3'd0;
            cursor_y    <= 3'd0;
            board_addr  <= 6'd0;
            turn        <= FIRST_STONE;
            stone_count <= 6'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cursor_x <= step_axis(cursor_x, btn_up, btn_down);
                cursor_y <= step_axis(cursor_y, btn_left, btn_right);
                // Address is taken from the pre-move cursor decoded this cycle.
                if (btn_place && !board_full) board_addr <= cell_addr;
            end
            if (state == WRITE) begin
                turn <= (turn == 2'b01) ? 2'b10 : 2'b01;
                if (stone_count != CELLS) stone_count <= stone_count + 6'd1;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign board_rd_en   = (state == READ);
    assign board_wr_en   = (state == WRITE);
    assign board_wr_data = turn;
    assign placed        = (state == WRITE);
    assign rejected      = (state == REJECT);
    assign board_full    = (stone_count == CELLS);

endmodule

// File: tb/tb_cursor_place_ctrl.sv
// Directed bench for cursor_place_ctrl; models the cell decoder as x*6+y.
module tb_cursor_place_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, btn_up, btn_down, btn_left, btn_right, btn_place;
    logic [2:0] cursor_x, cursor_y;
    logic [5:0] cell_addr, board_addr, stone_count;
    logic       board_rd_en, board_wr_en, busy, placed, rejected, board_full;
    logic [1:0] board_rd_data, board_wr_data, turn;

    int errors = 0;
    int checks = 0;
    int rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    assign cell_addr = 6'(cursor_x * 6 + cursor_y);

    cursor_place_ctrl #(.BOARD_N(6), .FIRST_STONE(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cell_addr(cell_addr),
        .board_addr(board_addr), .board_rd_en(board_rd_en), .board_rd_data(board_rd_data),
        .board_wr_en(board_wr_en), .board_wr_data(board_wr_data), .turn(turn),
        .busy(busy), .placed(placed), .rejected(rejected),
        .stone_count(stone_count), .board_full(board_full)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are sampled there and outputs observed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_btn();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_place = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cx"}, 8'(cursor_x), 8'd0);
        chk({tag, "_cy"}, 8'(cursor_y), 8'd0);
        chk({tag, "_turn"}, 8'(turn), 8'h01);
        chk({tag, "_cnt"}, 8'(stone_count), 8'd0);
        chk({tag, "_addr"}, 8'(board_addr), 8'd0);
        chk({tag, "_strobes"}, {3'b0, busy, board_rd_en, board_wr_en, placed, rejected}, 8'd0);
    endtask

    initial begin
        clr_btn();
        board_rd_data = 2'b00;
        rst_n = 0;
        #2;
        step();
        chk_reset("rst");
        rst_n = 1;

        // 1: cursor moves with wrap
        btn_up = 1; step(); clr_btn();
        chk("up_wrap", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd5, 3'd0});
        btn_left = 1; step(); clr_btn();
        chk("left_wrap", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd5, 3'd5});
        btn_down = 1; btn_right = 1; step(); clr_btn();
        chk("diag_wrap", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd0, 3'd0});
        btn_up = 1; btn_down = 1; step(); clr_btn();
        chk("axis_cancel", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd0, 3'd0});

        // 2: place on empty cell at (2,3)
        btn_down = 1; btn_right = 1; step();
        step(); clr_btn();
        btn_right = 1; step(); clr_btn();
        chk("cur_23", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd2, 3'd3});
        btn_place = 1; step(); clr_btn();
        chk("p_rd_en", 8'(board_rd_en), 8'd1);
        chk("p_addr", 8'(board_addr), 8'd15);
        chk("p_busy1", 8'(busy), 8'd1);
        board_rd_data = 2'b00;
        step();
        chk("p_t2_strobes", {6'b0, board_rd_en, board_wr_en}, 8'd0);
        step();
        chk("p_wr_en", 8'(board_wr_en), 8'd1);
        chk("p_wr_data", 8'(board_wr_data), 8'h01);
        chk("p_placed", 8'(placed), 8'd1);
        chk("p_addr_wr", 8'(board_addr), 8'd15);
        step();
        chk("p_turn", 8'(turn), 8'h02);
        chk("p_cnt", 8'(stone_count), 8'd1);
        chk("p_idle", {6'b0, busy, board_wr_en}, 8'd0);

        // 3: occupied cell rejects
        board_rd_data = 2'b01;
        btn_place = 1; step(); clr_btn();
        step(); step();
        chk("r_rejected", 8'(rejected), 8'd1);
        chk("r_no_wr", 8'(board_wr_en), 8'd0);
        step();
        chk("r_turn", 8'(turn), 8'h02);
        chk("r_cnt", 8'(stone_count), 8'd1);
        chk("r_pulse_end", 8'(rejected), 8'd0);

        // 4: spam place+left for four cycles
        board_rd_data = 2'b00;
        rd_cnt = 0; wr_cnt = 0;
        btn_place = 1; btn_left = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            rd_cnt += int'(board_rd_en);
            wr_cnt += int'(board_wr_en);
            if (board_wr_en) chk("s_wr_addr", 8'(board_addr), 8'd15);
        end
        clr_btn();
        chk("s_rd_cnt", 8'(rd_cnt), 8'd1);
        chk("s_wr_cnt", 8'(wr_cnt), 8'd1);
        chk("s_cursor", {2'b0, cursor_x, cursor_y}, {2'b0, 3'd2, 3'd2});
        chk("s_cnt", 8'(stone_count), 8'd2);
        chk("s_turn", 8'(turn), 8'h01);

        // 5: fill the board, then one more place
        wr_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            btn_place = 1; step(); clr_btn();
            for (int k = 0; k < 3; k++) begin
                wr_cnt += int'(board_wr_en);
                step();
            end
        end
        chk("f_wr_cnt", 8'(wr_cnt), 8'd34);
        chk("f_cnt", 8'(stone_count), 8'd36);
        chk("f_full", 8'(board_full), 8'd1);
        chk("f_turn", 8'(turn), 8'h01);
        btn_place = 1; step(); clr_btn();
        chk("f37_rd_en", 8'(board_rd_en), 8'd0);
        chk("f37_rejected", 8'(rejected), 8'd1);
        chk("f37_busy", 8'(busy), 8'd1);
        step();
        chk("f37_cnt", 8'(stone_count), 8'd36);
        chk("f37_idle", 8'(busy), 8'd0);

        // 6: reset during CHECK aborts the write
        rst_n = 0; step(); rst_n = 1;
        btn_down = 1; btn_right = 1; step(); clr_btn();
        btn_place = 1; step(); clr_btn();
        chk("a_rd_en", 8'(board_rd_en), 8'd1);
        chk("a_addr", 8'(board_addr), 8'd7);
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        chk_reset("a_rst");
        step();
        chk("a_no_wr", 8'(board_wr_en), 8'd0);
        step();
        chk("a_cnt", 8'(stone_count), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
